// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: difference and borrow of a - b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  // Purely combinational difference/borrow.
  always_comb begin
    diff   = a ^ b;
    borrow = ~a & b;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A start/busy/done handshake drives a three-state FSM; completed results
// and flags hold until the next accepted start commits a new result.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             accept, last;

  // Full-subtract step built from two half subtractors.
  logic x, y;
  logic d0, b0, d, b1, bout;

  assign x = sa[0];
  assign y = sb[0];

  half_subtractor u_hs0 (
    .a      (x),
    .b      (y),
    .diff   (d0),
    .borrow (b0)
  );

  half_subtractor u_hs1 (
    .a      (d0),
    .b      (bin),
    .diff   (d),
    .borrow (b1)
  );

  assign bout    = b0 | b1;
  assign res_nxt = {d, sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, accept/last strobes and handshake outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
          last      = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand shift registers, working result, borrow chain and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      bin <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      bin <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      sr  <= res_nxt;
      bin <= bout;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Result commit. On the final edge x/y are the original operand MSBs,
  // so signed overflow is taken directly from them and the new MSB d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else if (last) begin
      diff     <= res_nxt;
      borrow   <= bout;
      zero     <= (res_nxt == '0);
      overflow <= (x != y) && (d != x);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver pushes expected results
// from an arithmetic reference model; a monitor pops and compares on done.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow, zero, overflow;
  logic [WIDTH-1:0] diff;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
    exp_t e;
    int ua, ub, ud, sa, sb, sd;
    ua = int'(ma);
    ub = int'(mb);
    ud = ua - ub;
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    sd = sa - sb;
    e.diff   = ud[WIDTH-1:0];
    e.borrow = (ua < ub);
    e.zero   = (ua == ub);
    e.ovf    = (sd > 32767) || (sd < -32768);
    return e;
  endfunction

  // Monitor: handshake exclusivity every cycle; result compare on done.
  always @(negedge clk) begin
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff",     {16'd0, diff},        {16'd0, e.diff});
        check("borrow",   {31'd0, borrow},      {31'd0, e.borrow});
        check("zero",     {31'd0, zero},        {31'd0, e.zero});
        check("overflow", {31'd0, overflow},    {31'd0, e.ovf});
      end
    end
  end

  // Issue one operation at the current negedge and wait for done.
  // inject > 0 re-drives start with junk operands at that busy cycle.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input int inject);
    int lat, nbusy;
    bit got;
    start = 1'b1;
    a = oa;
    b = ob;
    last_exp = model(oa, ob);
    exp_q.push_back(last_exp);
    lat = 0;
    nbusy = 0;
    got = 0;
    while (lat < 4 * WIDTH && !got) begin
      @(negedge clk);
      lat++;
      start = (lat == inject);
      if (start) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      if (busy) nbusy++;
      if (done) got = 1;
    end
    start = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", lat, WIDTH + 1);
    check("busy_cycles", nbusy, WIDTH);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_done"},  {31'd0, done},     32'd0);
    check({tag, "_diff"},  {16'd0, diff},     32'd0);
    check({tag, "_borrow"},{31'd0, borrow},   32'd0);
    check({tag, "_zero"},  {31'd0, zero},     32'd1);
    check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, chained back-to-back (start in the DONE cycle).
    do_op(16'd5, 16'd3, -1);
    do_op(16'd3, 16'd5, -1);
    do_op(16'h8000, 16'h0001, -1);
    do_op(16'h1234, 16'h1234, -1);

    // Result holds after done with no new start.
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("hold_diff", {16'd0, diff}, {16'd0, last_exp.diff});
    @(negedge clk);

    // start mid-RUN is ignored.
    do_op(16'h0F0F, 16'h00FF, 5);
    @(negedge clk);
    check("no_restart", {31'd0, busy}, 32'd0);
    check("hold_diff2", {16'd0, diff}, {16'd0, last_exp.diff});

    // Reset in the middle of RUN aborts the operation.
    start = 1'b1;
    a = 16'h00F0;
    b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_idle", {31'd0, busy}, 32'd0);
    do_op(16'd7, 16'd2, -1);

    // Randomized operations, sometimes back-to-back, sometimes with gaps.
    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 7 == 0) rb = ra;
      if (i % 5 == 1) begin
        ra = 16'h8000 | ra;
        rb = rb & 16'h7FFF;
      end
      do_op(ra, rb, (i % 4 == 2) ? int'($urandom_range(2, WIDTH - 1)) : -1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
